// File: rtl/dispatch_scheduler.sv
// Frame-based block dispatcher: issues n_active_blocks dispatches per sample_tick, bounded by in-flight commits.
// Optional DISPATCH_SCHEDULER_OVERRUN_COUNT_EN adds a saturating overrun_count output.
module dispatch_scheduler #(
    parameter int unsigned n_blocks        = 256,
    parameter int unsigned max_outstanding = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          sample_tick,
    input  logic [$clog2(n_blocks):0]     n_active_blocks,
    output logic                          issue_valid,
    input  logic                          issue_ready,
    output logic [$clog2(n_blocks)-1:0]   issue_block,
    output logic [8:0]                    issue_commit_id,
    input  logic                          commit_done,
    output logic [8:0]                    outstanding,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          overrun,
    input  logic                          overrun_clear
`ifdef DISPATCH_SCHEDULER_OVERRUN_COUNT_EN
    ,
    output logic [15:0]                   overrun_count
`endif
);

    localparam int unsigned BW = $clog2(n_blocks);
    localparam int unsigned CW = BW + 1;
    localparam logic [9:0]  MAX_OUT = 10'(max_outstanding);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [BW-1:0]   blk_q, blk_d;
    logic [8:0]      cid_q, cid_d;
    logic [8:0]      outst_q, outst_d;
    logic            valid_q, valid_d;
    logic            fdone_q, fdone_d;
    logic            overrun_q, overrun_d;
    logic            hs, last, commit_ok, tick_ev, ovr_ev;
`ifdef DISPATCH_SCHEDULER_OVERRUN_COUNT_EN
    logic [15:0]     ovc_q, ovc_d;
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        blk_d     = blk_q;
        cid_d     = cid_q;
        outst_d   = outst_q;
        valid_d   = valid_q;
        fdone_d   = 1'b0;
        hs        = valid_q & issue_ready;
        last      = ({1'b0, blk_q} == (count_q - CW'(1)));
        commit_ok = commit_done & (outst_q != '0);
        tick_ev   = enable & sample_tick;
        ovr_ev    = tick_ev & (state_q != IDLE);
        overrun_d = ovr_ev | (overrun_q & ~overrun_clear);

        if (hs && !commit_ok) begin
            outst_d = outst_q + 9'd1;
        end else if (!hs && commit_ok) begin
            outst_d = outst_q - 9'd1;
        end

        // A request already shown completes even if enable dropped meanwhile.
        if (hs) begin
            blk_d = blk_q + BW'(1);
            cid_d = cid_q + 9'd1;
        end

        case (state_q)
            IDLE: begin
                if (tick_ev) begin
                    count_d = n_active_blocks;
                    blk_d   = '0;
                    state_d = (n_active_blocks == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (hs && last) begin
                    state_d = DRAIN;
                    valid_d = 1'b0;
                end else if (hs || !valid_q) begin
                    // Look-ahead on next outstanding sustains one dispatch per clock.
                    valid_d = enable && ({1'b0, outst_d} < MAX_OUT);
                end
            end
            DRAIN: begin
                if (enable && (outst_q == '0)) begin
                    state_d = IDLE;
                    fdone_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef DISPATCH_SCHEDULER_OVERRUN_COUNT_EN
    always_comb begin
        ovc_d = ovc_q;
        if (ovr_ev && (ovc_q != '1)) begin
            ovc_d = ovc_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovc_q <= '0;
        end else begin
            ovc_q <= ovc_d;
        end
    end

    assign overrun_count = ovc_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            blk_q     <= '0;
            cid_q     <= '0;
            outst_q   <= '0;
            valid_q   <= 1'b0;
            fdone_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            blk_q     <= blk_d;
            cid_q     <= cid_d;
            outst_q   <= outst_d;
            valid_q   <= valid_d;
            fdone_q   <= fdone_d;
            overrun_q <= overrun_d;
        end
    end

    assign issue_valid     = valid_q;
    assign issue_block     = blk_q;
    assign issue_commit_id = cid_q;
    assign outstanding     = outst_q;
    assign busy            = (state_q != IDLE);
    assign frame_done      = fdone_q;
    assign overrun         = overrun_q;

endmodule
